// File: rtl/exmem_skid_buffer.sv
// EX/MEM pipeline register with a ready/valid handshake on both sides.
// A 2-entry skid, a synchronous flush for branch squash and a saturating stall counter.
module exmem_skid_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] inAdder,
    input  logic              inZf,
    input  logic [DATA_W-1:0] inOutAlu,
    input  logic [DATA_W-1:0] inRD2,
    input  logic [REG_W-1:0]  inMux5b,
    input  logic [CTRL_W-1:0] inCtrl,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outAdder,
    output logic              outZf,
    output logic [DATA_W-1:0] outOutAlu,
    output logic [DATA_W-1:0] outRD2,
    output logic [REG_W-1:0]  outMux5b,
    output logic [CTRL_W-1:0] outCtrl,
    output logic [CNT_W-1:0]  stallCount
);

    localparam int PAY_W = 3 * DATA_W + REG_W + CTRL_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Bit 0 is the main-register valid and bit 1 the skid valid, so both handshake flags come straight from flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [PAY_W-1:0]  inPay;
    logic [PAY_W-1:0]  mainPay;
    logic [PAY_W-1:0]  skidPay;
    logic [CNT_W-1:0]  stallCnt;
    logic              skidValid;
    logic              accept;
    logic              deliver;
    logic              loadMain;
    logic              mainFromSkid;
    logic              loadSkid;

    assign inPay     = {inAdder, inZf, inOutAlu, inRD2, inMux5b, inCtrl};
    assign outValid  = state[0];
    assign skidValid = state[1];
    assign inReady   = ~skidValid;
    assign accept    = inValid & inReady;
    assign deliver   = outValid & outReady;

    assign {outAdder, outZf, outOutAlu, outRD2, outMux5b, outCtrl} = mainPay;
    assign stallCount = stallCnt;

    // Next-state and register-load decode; flush overrides every transition.
    always_comb begin
        stateNext    = state;
        loadMain     = 1'b0;
        mainFromSkid = 1'b0;
        loadSkid     = 1'b0;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        loadMain  = 1'b1;
                        stateNext = HALF;
                    end else begin
                        stateNext = EMPTY;
                    end
                end
                HALF: begin
                    if (accept && deliver) begin
                        loadMain  = 1'b1;
                        stateNext = HALF;
                    end else if (accept) begin
                        loadSkid  = 1'b1;
                        stateNext = FULL;
                    end else if (deliver) begin
                        stateNext = EMPTY;
                    end else begin
                        stateNext = HALF;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        mainFromSkid = 1'b1;
                        stateNext    = HALF;
                    end else begin
                        stateNext = FULL;
                    end
                end
                default: begin
                    stateNext = EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Payload registers; contents are left untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainPay <= {PAY_W{1'b0}};
            skidPay <= {PAY_W{1'b0}};
        end else begin
            if (loadMain) begin
                mainPay <= inPay;
            end else if (mainFromSkid) begin
                mainPay <= skidPay;
            end
            if (loadSkid) begin
                skidPay <= inPay;
            end
        end
    end

    // Saturating count of cycles where a held beat is refused downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= {CNT_W{1'b0}};
        end else if (outValid && !outReady && !flush && (stallCnt != CNT_MAX)) begin
            stallCnt <= stallCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_exmem_skid_buffer.sv
// Randomised and directed bench for exmem_skid_buffer against a queue-based model of the stage.
module tb_exmem_skid_buffer;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 3;
    localparam int PW     = 3 * DATA_W + REG_W + CTRL_W + 1;
    localparam int SAT    = 7;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] inAdder;
    logic              inZf;
    logic [DATA_W-1:0] inOutAlu;
    logic [DATA_W-1:0] inRD2;
    logic [REG_W-1:0]  inMux5b;
    logic [CTRL_W-1:0] inCtrl;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outAdder;
    logic              outZf;
    logic [DATA_W-1:0] outOutAlu;
    logic [DATA_W-1:0] outRD2;
    logic [REG_W-1:0]  outMux5b;
    logic [CTRL_W-1:0] outCtrl;
    logic [CNT_W-1:0]  stallCount;
    logic [PW-1:0]     outPay;

    logic [PW-1:0] q[$];
    logic [PW-1:0] lastOut;
    logic [PW-1:0] pC;
    int            stallM;
    int            checks;
    int            errors;
    bit            checkEn;

    exmem_skid_buffer #(
        .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .inValid(inValid), .inReady(inReady),
        .inAdder(inAdder), .inZf(inZf), .inOutAlu(inOutAlu), .inRD2(inRD2),
        .inMux5b(inMux5b), .inCtrl(inCtrl),
        .outValid(outValid), .outReady(outReady),
        .outAdder(outAdder), .outZf(outZf), .outOutAlu(outOutAlu), .outRD2(outRD2),
        .outMux5b(outMux5b), .outCtrl(outCtrl),
        .stallCount(stallCount)
    );

    assign outPay = {outAdder, outZf, outOutAlu, outRD2, outMux5b, outCtrl};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] randPay(input logic [DATA_W-1:0] alu);
        logic [PW-1:0] p;
        p = {DATA_W'($urandom()), 1'($urandom_range(0, 1)), alu, DATA_W'($urandom()),
             REG_W'($urandom_range(0, 31)), CTRL_W'($urandom_range(0, 15))};
        return p;
    endfunction

    task automatic modelClear();
        q.delete();
        lastOut = '0;
        stallM  = 0;
    endtask

    // One clock: apply inputs, let the edge happen, then advance the model by the stage's rules.
    task automatic cycle(input logic iv, input logic [PW-1:0] p, input logic ordy, input logic fl);
        bit rdy;
        bit vld;
        inValid  = iv;
        {inAdder, inZf, inOutAlu, inRD2, inMux5b, inCtrl} = p;
        outReady = ordy;
        flush    = fl;
        rdy = (q.size() < 2);
        vld = (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (vld && !ordy && stallM < SAT) stallM++;
            if (vld && ordy) void'(q.pop_front());
            if (iv && rdy) q.push_back(p);
        end
        if (q.size() > 0) lastOut = q[0];
        #1;
    endtask

    // Asynchronous reset asserted between edges, released one edge later.
    task automatic midReset();
        #2;
        rst_n   = 1'b0;
        inValid = 1'b0;
        flush   = 1'b0;
        modelClear();
        #1;
        chk("rst_outValid", outValid, 1'b0);
        chk("rst_inReady", inReady, 1'b1);
        chk("rst_outOutAlu", outOutAlu, 32'h0);
        chk("rst_outMux5b", outMux5b, 5'h0);
        chk("rst_stallCount", stallCount, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Every falling edge: DUT outputs must match the model's view of the stage.
    always @(negedge clk) begin
        if (checkEn) begin
            chk("outValid", outValid, q.size() > 0);
            chk("inReady", inReady, q.size() < 2);
            chk("payload", outPay, lastOut);
            chk("stallCount", stallCount, stallM);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        checkEn = 1'b0;
        rst_n = 1'b1;
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b0;
        {inAdder, inZf, inOutAlu, inRD2, inMux5b, inCtrl} = '0;
        modelClear();
        #1;
        rst_n = 1'b0;
        #1;
        checkEn = 1'b1;
        chk("init_outValid", outValid, 1'b0);
        chk("init_inReady", inReady, 1'b1);
        chk("init_outOutAlu", outOutAlu, 32'h0);
        chk("init_stallCount", stallCount, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming at full rate
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, randPay(DATA_W'(k)), 1'b1, 1'b0);
            chk("stream_alu", outOutAlu, k);
            chk("stream_valid", outValid, 1'b1);
            chk("stream_ready", inReady, 1'b1);
        end
        cycle(1'b0, randPay(32'h0), 1'b1, 1'b0);
        chk("stream_drain", outValid, 1'b0);

        // Backpressure: A and B fill the stage, C waits
        pC = randPay(32'h30);
        cycle(1'b1, randPay(32'h10), 1'b0, 1'b0);
        cycle(1'b1, randPay(32'h20), 1'b0, 1'b0);
        chk("bp_full_ready", inReady, 1'b0);
        chk("bp_stall1", stallCount, 3'd1);
        chk("bp_headA", outOutAlu, 32'h10);
        cycle(1'b1, pC, 1'b0, 1'b0);
        chk("bp_refuseC", inReady, 1'b0);
        chk("bp_stall2", stallCount, 3'd2);
        cycle(1'b1, pC, 1'b1, 1'b0);
        chk("bp_headB", outOutAlu, 32'h20);
        cycle(1'b1, pC, 1'b1, 1'b0);
        chk("bp_headC", outOutAlu, 32'h30);
        cycle(1'b0, pC, 1'b1, 1'b0);
        chk("bp_drained", outValid, 1'b0);

        // Flush while FULL with a beat offered
        cycle(1'b1, randPay(32'h40), 1'b0, 1'b0);
        cycle(1'b1, randPay(32'h50), 1'b0, 1'b0);
        cycle(1'b1, randPay(32'h99), 1'b0, 1'b1);
        chk("flush_valid", outValid, 1'b0);
        chk("flush_ready", inReady, 1'b1);
        chk("flush_hold", outOutAlu, 32'h40);
        chk("flush_stall", stallCount, 3'd3);
        cycle(1'b0, randPay(32'h0), 1'b1, 1'b0);
        chk("flush_no99", outValid, 1'b0);

        // Stall counter saturation
        cycle(1'b1, randPay(32'h77), 1'b0, 1'b0);
        repeat (12) cycle(1'b0, randPay(32'h0), 1'b0, 1'b0);
        chk("sat_count", stallCount, 3'd7);
        chk("sat_hold", outOutAlu, 32'h77);
        chk("sat_valid", outValid, 1'b1);

        midReset();

        // Random traffic with occasional flushes and resets
        for (int r = 0; r < 6; r++) begin
            repeat (500) begin
                cycle(1'($urandom_range(0, 1)), randPay(DATA_W'($urandom())),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
            end
            midReset();
        end

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
